fft_stage_seq: RTL and testbench

FFT_STAGE_SEQ -- requirements
Module: fft_stage_seq

---
 rtl/fft_pkg.sv | 17 +
 rtl/fft_stage_seq_if.sv | 59 +++++
 rtl/fft_en_delay.sv | 40 ++++
 rtl/fft_stage_seq.sv | 151 +++++++++++++++
 tb/tb_fft_stage_seq.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fft_pkg.sv
// Shared definitions for the FFT stage sequencer: default geometry of a
// block (lanes, points, chunks), the issue-to-CBFP pipeline latency and the
// sequencer state encoding.
package fft_pkg;

  localparam int DEF_NUM_PATHS  = 16;
  localparam int DEF_BLOCK_SIZE = 512;
  localparam int DEF_NUM_CHUNKS = DEF_BLOCK_SIZE / DEF_NUM_PATHS;
  localparam int DEF_PIPE_LAT   = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } seq_state_t;

endpackage

// File: rtl/fft_stage_seq_if.sv
// Bundle of the sequencer's request input and its issue/CBFP/status outputs.
// master: the sequencer side. slave: the consumer that raises di_en and
// watches the outputs.
// Optional macro FFT_SEQ_FRAME_CNT_EN adds the 16-bit frame_cnt signal.
interface fft_stage_seq_if
  import fft_pkg::*;
#(
  parameter int NUM_PATHS  = DEF_NUM_PATHS,
  parameter int BLOCK_SIZE = DEF_BLOCK_SIZE
);

  localparam int NUM_CHUNKS = BLOCK_SIZE / NUM_PATHS;
  localparam int CW         = $clog2(NUM_CHUNKS);
  localparam int AW         = $clog2(BLOCK_SIZE);

  logic                           di_en;
  logic                           issue_valid;
  logic [CW-1:0]                  chunk_idx;
  logic [NUM_PATHS-1:0][AW-1:0]   tw_addr;
  logic                           cbfp_en;
  logic [CW-1:0]                  cbfp_cnt;
  logic                           busy;
  logic                           done;
  logic                           err_abort;
`ifdef FFT_SEQ_FRAME_CNT_EN
  logic [15:0]                    frame_cnt;
`endif

  modport master (
    input  di_en,
    output issue_valid,
    output chunk_idx,
    output tw_addr,
    output cbfp_en,
    output cbfp_cnt,
    output busy,
    output done,
    output err_abort
`ifdef FFT_SEQ_FRAME_CNT_EN
    , output frame_cnt
`endif
  );

  modport slave (
    output di_en,
    input  issue_valid,
    input  chunk_idx,
    input  tw_addr,
    input  cbfp_en,
    input  cbfp_cnt,
    input  busy,
    input  done,
    input  err_abort
`ifdef FFT_SEQ_FRAME_CNT_EN
    , input frame_cnt
`endif
  );

endinterface

// File: rtl/fft_en_delay.sv
// PIPE_LAT-deep 1-bit shift register carrying the issue strobe down to the
// CBFP input. A synchronous clear flushes everything in flight when a block
// is abandoned. en_next exposes the value the output tap takes at the next
// edge so that logic registered alongside dout can stay aligned with it.
module fft_en_delay
  import fft_pkg::*;
#(
  parameter int PIPE_LAT = DEF_PIPE_LAT
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic din,
  output logic dout,
  output logic en_next,
  output logic any
);

  logic [PIPE_LAT-1:0] taps;
  logic [PIPE_LAT-1:0] taps_next;

  // Shift one place per cycle; the oldest bit falls off the top.
  always_comb begin
    taps_next = clr ? '0 : PIPE_LAT'({taps, din});
  end

  // Delay-line storage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      taps <= '0;
    end else begin
      taps <= taps_next;
    end
  end

  assign dout    = taps[PIPE_LAT-1];
  assign en_next = taps_next[PIPE_LAT-1];
  assign any     = |taps;

endmodule

// File: rtl/fft_stage_seq.sv
// FFT stage sequencer: turns a level request (di_en) into a stream of chunk
// issues with per-lane twiddle ROM addresses, and re-times the issue strobe
// to the CBFP input with a chunk position counter and end-of-block pulse.
// Blocks run back to back while di_en stays high; dropping di_en mid-block
// aborts the block and flushes the pipeline.
// Optional macro FFT_SEQ_FRAME_CNT_EN adds a 16-bit count of completed blocks.
module fft_stage_seq
  import fft_pkg::*;
#(
  parameter int NUM_PATHS  = DEF_NUM_PATHS,
  parameter int BLOCK_SIZE = DEF_BLOCK_SIZE,
  parameter int PIPE_LAT   = DEF_PIPE_LAT
) (
  input  logic                   clk,
  input  logic                   rst,
  fft_stage_seq_if.master        bus
);

  localparam int NUM_CHUNKS = BLOCK_SIZE / NUM_PATHS;
  localparam int CW         = $clog2(NUM_CHUNKS);
  localparam int AW         = $clog2(BLOCK_SIZE);
  localparam logic [CW-1:0] LAST_CHUNK = CW'(NUM_CHUNKS - 1);

  seq_state_t                   state;
  logic                         issue_valid_r;
  logic [CW-1:0]                chunk_idx_r;
  logic [NUM_PATHS-1:0][AW-1:0] tw_addr_r;
  logic                         err_abort_r;

  logic                         issue_now;
  logic                         abort_now;
  logic [CW-1:0]                idx_next;

  logic                         cbfp_en;
  logic                         cbfp_en_next;
  logic                         line_any;
  logic [CW-1:0]                cbfp_cnt_r;
  logic [CW-1:0]                cbfp_cnt_next;
  logic                         done_r;
  logic                         done_next;

  // Decide whether a chunk is issued this edge and whether the block is
  // being abandoned (request dropped before the last chunk).
  always_comb begin
    issue_now = 1'b0;
    abort_now = 1'b0;
    idx_next  = chunk_idx_r;
    case (state)
      IDLE: begin
        if (bus.di_en) begin
          issue_now = 1'b1;
          idx_next  = '0;
        end
      end
      RUN: begin
        if (bus.di_en) begin
          issue_now = 1'b1;
          idx_next  = (chunk_idx_r == LAST_CHUNK) ? '0 : chunk_idx_r + CW'(1);
        end else begin
          abort_now = (chunk_idx_r != LAST_CHUNK);
        end
      end
      default: ;
    endcase
  end

  // Sequencer FSM with registered issue strobe, chunk index, twiddle
  // addresses and abort pulse. Index and addresses hold between issues.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      issue_valid_r <= 1'b0;
      chunk_idx_r   <= '0;
      tw_addr_r     <= '0;
      err_abort_r   <= 1'b0;
    end else begin
      issue_valid_r <= issue_now;
      err_abort_r   <= abort_now;
      if (issue_now) begin
        chunk_idx_r <= idx_next;
        for (int k = 0; k < NUM_PATHS; k++) begin
          tw_addr_r[k] <= AW'(idx_next) * AW'(NUM_PATHS) + AW'(k);
        end
      end
      case (state)
        IDLE:    if (bus.di_en) state <= RUN;
        RUN:     if (!bus.di_en) state <= DRAIN;
        DRAIN:   if (!line_any) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  fft_en_delay #(
    .PIPE_LAT (PIPE_LAT)
  ) u_en_delay (
    .clk     (clk),
    .rst     (rst),
    .clr     (abort_now),
    .din     (issue_valid_r),
    .dout    (cbfp_en),
    .en_next (cbfp_en_next),
    .any     (line_any)
  );

  // Chunk position as seen by CBFP: restarts at 0 on each new run of
  // cbfp_en, wraps per block, and reads 0 whenever cbfp_en is low.
  always_comb begin
    cbfp_cnt_next = '0;
    if (cbfp_en_next && cbfp_en) begin
      cbfp_cnt_next = (cbfp_cnt_r == LAST_CHUNK) ? '0 : cbfp_cnt_r + CW'(1);
    end
    done_next = cbfp_en_next && (cbfp_cnt_next == LAST_CHUNK);
  end

  // CBFP counter and end-of-block pulse, registered in step with cbfp_en.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cbfp_cnt_r <= '0;
      done_r     <= 1'b0;
    end else begin
      cbfp_cnt_r <= cbfp_cnt_next;
      done_r     <= done_next;
    end
  end

`ifdef FFT_SEQ_FRAME_CNT_EN
  logic [15:0] frame_cnt_r;

  // Completed-block counter, wraps naturally at 16 bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt_r <= '0;
    end else if (done_next) begin
      frame_cnt_r <= frame_cnt_r + 16'd1;
    end
  end

  assign bus.frame_cnt = frame_cnt_r;
`endif

  assign bus.issue_valid = issue_valid_r;
  assign bus.chunk_idx   = chunk_idx_r;
  assign bus.tw_addr     = tw_addr_r;
  assign bus.cbfp_en     = cbfp_en;
  assign bus.cbfp_cnt    = cbfp_cnt_r;
  assign bus.done        = done_r;
  assign bus.err_abort   = err_abort_r;
  assign bus.busy        = (state != IDLE) || line_any;

endmodule

// File: tb/tb_fft_stage_seq.sv
// Self-checking bench for fft_stage_seq (default parameters). Each scenario
// drives a di_en pattern, records the DUT outputs one edge at a time, and
// compares them with a trace-level reference model built from the block
// rules: issue one cycle after a sampled request, CBFP strobe PIPE_LAT
// cycles after issue unless an abort lands while it is in flight.
module tb_fft_stage_seq;

  localparam int NC   = 32;
  localparam int NP   = 16;
  localparam int PL   = 3;
  localparam int MAXN = 400;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  fft_stage_seq_if bus ();

  fft_stage_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  bit          din   [MAXN];
  logic [63:0] obs   [MAXN+1];
  logic [63:0] expv  [MAXN+1];
  int          e_iv  [MAXN+1];
  int          e_ab  [MAXN+1];
  int          e_idx [MAXN+1];
  int          e_iss [MAXN+1];
  int          e_busy[MAXN+1];
  int          e_en  [MAXN+1];
  int          e_cnt [MAXN+1];
  int          e_done[MAXN+1];

  // Bit map: [41] issue_valid [40:36] chunk_idx [35] cbfp_en [34:30] cbfp_cnt
  // [29] done [28] err_abort [27] busy [26:18] tw0 [17:9] tw7 [8:0] tw15
  function automatic logic [63:0] pack(input logic iv, input logic [4:0] idx,
                                       input logic en, input logic [4:0] cnt,
                                       input logic dn, input logic er, input logic bz,
                                       input logic [8:0] a0, input logic [8:0] a7,
                                       input logic [8:0] a15);
    return {22'd0, iv, idx, en, cnt, dn, er, bz, a0, a7, a15};
  endfunction

  // True if some issued chunk is still travelling toward the CBFP after edge u.
  function automatic bit occupied(input int u);
    for (int s = u - PL; s <= u - 1; s++) begin
      if (s >= 1 && e_iv[s] != 0) begin
        bit killed = 1'b0;
        for (int a = s + 1; a <= u; a++) if (e_ab[a] != 0) killed = 1'b1;
        if (!killed) return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  // Reference trace for edges 1..n given din[0..n-1], starting from reset.
  function automatic void build_expect(input int n);
    int mode;
    int idx;
    int issued;
    bit d;
    mode = 0; idx = 0; issued = 0;
    for (int t = 0; t <= n; t++) begin
      e_iv[t] = 0; e_ab[t] = 0; e_idx[t] = 0; e_iss[t] = 0;
      e_busy[t] = 0; e_en[t] = 0; e_cnt[t] = 0; e_done[t] = 0;
    end
    for (int t = 1; t <= n; t++) begin
      d = din[t-1];
      if (mode == 0) begin
        if (d) begin e_iv[t] = 1; idx = 0; mode = 1; issued = 1; end
      end else if (mode == 1) begin
        if (d) begin
          e_iv[t] = 1;
          idx = (idx + 1) % NC;
        end else begin
          e_ab[t] = (idx != NC - 1) ? 1 : 0;
          mode = 2;
        end
      end else begin
        if (!occupied(t - 1)) mode = 0;
      end
      e_idx[t]  = idx;
      e_iss[t]  = issued;
      e_busy[t] = (mode != 0 || occupied(t)) ? 1 : 0;
    end
    for (int t = 1; t <= n; t++) begin
      if (t > PL && e_iv[t-PL] != 0) begin
        e_en[t] = 1;
        for (int a = t - PL + 1; a <= t; a++) if (e_ab[a] != 0) e_en[t] = 0;
      end
      if (e_en[t] != 0) e_cnt[t] = (e_en[t-1] != 0) ? (e_cnt[t-1] + 1) % NC : 0;
      e_done[t] = (e_en[t] != 0 && e_cnt[t] == NC - 1) ? 1 : 0;
      expv[t] = pack(e_iv[t] != 0, 5'(e_idx[t]), e_en[t] != 0, 5'(e_cnt[t]),
                     e_done[t] != 0, e_ab[t] != 0, e_busy[t] != 0,
                     (e_iss[t] != 0) ? 9'(e_idx[t] * NP + 0)  : 9'd0,
                     (e_iss[t] != 0) ? 9'(e_idx[t] * NP + 7)  : 9'd0,
                     (e_iss[t] != 0) ? 9'(e_idx[t] * NP + 15) : 9'd0);
    end
  endfunction

  task automatic do_reset();
    bus.di_en = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic run_trace(input int n);
    for (int c = 0; c < n; c++) begin
      bus.di_en = din[c];
      @(posedge clk);
      #1;
      obs[c+1] = pack(bus.issue_valid, bus.chunk_idx, bus.cbfp_en, bus.cbfp_cnt,
                      bus.done, bus.err_abort, bus.busy,
                      bus.tw_addr[0], bus.tw_addr[7], bus.tw_addr[15]);
    end
    bus.di_en = 1'b0;
  endtask

  task automatic fill(input int from, input int len, input bit v);
    for (int i = from; i < from + len; i++) din[i] = v;
  endtask

  task automatic test_reset();
    bus.di_en = 1'b1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (pack(bus.issue_valid, bus.chunk_idx, bus.cbfp_en, bus.cbfp_cnt, bus.done,
             bus.err_abort, bus.busy, 9'd0, 9'd0, 9'd0) !== 64'd0) begin
      failures++;
      $display("FAIL reset_outputs got iv=%b idx=%0d en=%b cnt=%0d done=%b err=%b busy=%b want all 0",
               bus.issue_valid, bus.chunk_idx, bus.cbfp_en, bus.cbfp_cnt, bus.done,
               bus.err_abort, bus.busy);
    end
    checks++;
    if (bus.tw_addr !== '0) begin
      failures++;
      $display("FAIL reset_tw_addr got %h want 0", bus.tw_addr);
    end
`ifdef FFT_SEQ_FRAME_CNT_EN
    checks++;
    if (bus.frame_cnt !== 16'd0) begin
      failures++;
      $display("FAIL reset_frame_cnt got %0d want 0", bus.frame_cnt);
    end
`endif
    bus.di_en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (bus.issue_valid !== 1'b0 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_release_idle got iv=%b busy=%b want 0 0", bus.issue_valid, bus.busy);
    end
  endtask

  task automatic test_single_block();
    int n = 50;
    int ndone = 0;
    int first_en = -1;
    fill(0, 32, 1'b1);
    fill(32, 18, 1'b0);
    do_reset();
    run_trace(n);
    build_expect(n);
    for (int t = 1; t <= n; t++) begin
      checks++;
      if (obs[t] !== expv[t]) begin
        failures++;
        $display("FAIL single_block edge %0d got %h want %h", t, obs[t], expv[t]);
      end
      if (obs[t][29]) ndone++;
      if (obs[t][35] && first_en < 0) first_en = t;
    end
    checks++;
    if (ndone != 1) begin failures++; $display("FAIL single_done_count got %0d want 1", ndone); end
    checks++;
    if (first_en != 4) begin failures++; $display("FAIL single_first_cbfp_edge got %0d want 4", first_en); end
    checks++;
    if (obs[32][8:0] !== 9'd511) begin
      failures++;
      $display("FAIL single_tw15_last got %0d want 511", obs[32][8:0]);
    end
    checks++;
    if (obs[n][27] !== 1'b0) begin failures++; $display("FAIL single_busy_end got %b want 0", obs[n][27]); end
  endtask

  task automatic test_back_to_back();
    int n = 80;
    int d0 = -1;
    int d1 = -1;
    fill(0, 64, 1'b1);
    fill(64, 16, 1'b0);
    do_reset();
    run_trace(n);
    build_expect(n);
    for (int t = 1; t <= n; t++) begin
      checks++;
      if (obs[t] !== expv[t]) begin
        failures++;
        $display("FAIL back_to_back edge %0d got %h want %h", t, obs[t], expv[t]);
      end
      if (obs[t][29]) begin
        if (d0 < 0) d0 = t; else if (d1 < 0) d1 = t;
      end
    end
    checks++;
    if (d0 != 35 || d1 != 67) begin
      failures++;
      $display("FAIL b2b_done_edges got %0d,%0d want 35,67", d0, d1);
    end
    checks++;
    if (obs[36][35] !== 1'b1 || obs[36][34:30] !== 5'd0 || obs[35][34:30] !== 5'd31) begin
      failures++;
      $display("FAIL b2b_cbfp_wrap got en=%b cnt %0d->%0d want en=1 cnt 31->0",
               obs[36][35], obs[35][34:30], obs[36][34:30]);
    end
  endtask

  task automatic test_abort();
    int n = 30;
    int nerr = 0;
    int nen = 0;
    int ndone = 0;
    fill(0, 10, 1'b1);
    fill(10, 20, 1'b0);
    do_reset();
    run_trace(n);
    build_expect(n);
    for (int t = 1; t <= n; t++) begin
      checks++;
      if (obs[t] !== expv[t]) begin
        failures++;
        $display("FAIL abort edge %0d got %h want %h", t, obs[t], expv[t]);
      end
      if (obs[t][28]) nerr++;
      if (obs[t][35]) nen++;
      if (obs[t][29]) ndone++;
    end
    checks++;
    if (nerr != 1 || obs[11][28] !== 1'b1) begin
      failures++;
      $display("FAIL abort_err_pulse got count=%0d at11=%b want 1 1", nerr, obs[11][28]);
    end
    checks++;
    if (nen != 7) begin failures++; $display("FAIL abort_cbfp_count got %0d want 7", nen); end
    checks++;
    if (ndone != 0) begin failures++; $display("FAIL abort_no_done got %0d want 0", ndone); end
    checks++;
    if (obs[12][27] !== 1'b0) begin failures++; $display("FAIL abort_idle_busy got %b want 0", obs[12][27]); end
  endtask

  task automatic test_drain_ignore();
    int n = 89;
    int restart = -1;
    fill(0, 32, 1'b1);
    fill(32, 1, 1'b0);
    fill(33, 36, 1'b1);
    fill(69, 20, 1'b0);
    do_reset();
    run_trace(n);
    build_expect(n);
    for (int t = 1; t <= n; t++) begin
      checks++;
      if (obs[t] !== expv[t]) begin
        failures++;
        $display("FAIL drain_ignore edge %0d got %h want %h", t, obs[t], expv[t]);
      end
      if (t > 33 && obs[t][41] && restart < 0) restart = t;
    end
    checks++;
    if (restart != 38) begin failures++; $display("FAIL drain_restart_edge got %0d want 38", restart); end
  endtask

  task automatic test_reset_mid();
    int n = 45;
    do_reset();
    bus.di_en = 1'b1;
    repeat (21) @(posedge clk);
    #1;
    checks++;
    if (bus.chunk_idx !== 5'd20) begin failures++; $display("FAIL mid_chunk20 got %0d want 20", bus.chunk_idx); end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (pack(bus.issue_valid, bus.chunk_idx, bus.cbfp_en, bus.cbfp_cnt, bus.done,
             bus.err_abort, bus.busy, 9'd0, 9'd0, 9'd0) !== 64'd0 || bus.tw_addr !== '0) begin
      failures++;
      $display("FAIL mid_reset_immediate got iv=%b idx=%0d en=%b cnt=%0d err=%b busy=%b tw=%h want all 0",
               bus.issue_valid, bus.chunk_idx, bus.cbfp_en, bus.cbfp_cnt, bus.err_abort,
               bus.busy, bus.tw_addr);
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (bus.done !== 1'b0 || bus.issue_valid !== 1'b0 || bus.err_abort !== 1'b0) begin
        failures++;
        $display("FAIL mid_reset_hold got done=%b iv=%b err=%b want 0 0 0",
                 bus.done, bus.issue_valid, bus.err_abort);
      end
    end
    bus.di_en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    fill(0, 3, 1'b0);
    fill(3, 32, 1'b1);
    fill(35, 10, 1'b0);
    run_trace(n);
    build_expect(n);
    for (int t = 1; t <= n; t++) begin
      checks++;
      if (obs[t] !== expv[t]) begin
        failures++;
        $display("FAIL after_mid_reset edge %0d got %h want %h", t, obs[t], expv[t]);
      end
    end
    checks++;
    if (obs[4][41] !== 1'b1 || obs[4][40:36] !== 5'd0) begin
      failures++;
      $display("FAIL mid_restart_chunk0 got iv=%b idx=%0d want 1 0", obs[4][41], obs[4][40:36]);
    end
  endtask

  task automatic test_random(input int round);
    int n = 300;
    int c = 0;
    int r;
    int len;
    while (c < n) begin
      r = $urandom_range(0, 3);
      len = (r == 0) ? NC : (r == 1) ? 2 * NC : $urandom_range(1, 40);
      for (int i = 0; i < len && c < n; i++) begin din[c] = 1'b1; c++; end
      len = $urandom_range(0, 8);
      for (int i = 0; i < len && c < n; i++) begin din[c] = 1'b0; c++; end
    end
    do_reset();
    run_trace(n);
    build_expect(n);
    for (int t = 1; t <= n; t++) begin
      checks++;
      if (obs[t] !== expv[t]) begin
        failures++;
        $display("FAIL random%0d edge %0d got %h want %h", round, t, obs[t], expv[t]);
      end
    end
  endtask

`ifdef FFT_SEQ_FRAME_CNT_EN
  task automatic test_frame_cnt();
    int n = 106;
    int ndone = 0;
    fill(0, 96, 1'b1);
    fill(96, 10, 1'b0);
    do_reset();
    run_trace(n);
    build_expect(n);
    for (int t = 1; t <= n; t++) ndone += e_done[t];
    checks++;
    if (bus.frame_cnt !== 16'(ndone) || bus.frame_cnt !== 16'd3) begin
      failures++;
      $display("FAIL frame_cnt got %0d want 3", bus.frame_cnt);
    end
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    bus.di_en = 1'b0;
    rst = 1'b1;
    test_reset();
    test_single_block();
    test_back_to_back();
    test_abort();
    test_drain_ignore();
    test_reset_mid();
    test_random(0);
    test_random(1);
`ifdef FFT_SEQ_FRAME_CNT_EN
    test_frame_cnt();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
